// File: rtl/approx_sched_pkg.sv
// approx_sched_pkg: shared definitions for the approximate-adder scheduler.
//   - post-process mode constants (RAW / SAT / AVG; code 3 behaves as RAW)
//   - FSM state encoding
//   - post_process(): turns the 9-bit adder sum into the returned result
package approx_sched_pkg;

  localparam logic [1:0] MODE_RAW = 2'd0;
  localparam logic [1:0] MODE_SAT = 2'd1;
  localparam logic [1:0] MODE_AVG = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // SAT clamps to 8 bits, AVG is the floor of sum/2, anything else is raw.
  function automatic logic [8:0] post_process(input logic [8:0] sum, input logic [1:0] mode);
    logic [8:0] res;
    case (mode)
      MODE_SAT: res = sum[8] ? 9'h0FF : {1'b0, sum[7:0]};
      MODE_AVG: res = {1'b0, sum[8:1]};
      default:  res = sum;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/approx_adder_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index with highest priority this cycle (must be < NREQ)
//   en    : when low, no grant is issued
//   grant : one-hot grant (all zero if en low or no request)
//   idx   : encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic           found_s;
  logic           hit_s;
  logic [IDW:0]   sum_s;
  logic [IDW:0]   pos_s;

  // Walk the slots starting at ptr, wrapping at NREQ; the first requester seen wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    sum_s   = '0;
    pos_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s   = {1'b0, ptr} + (IDW+1)'(k);
      pos_s   = (sum_s >= (IDW+1)'(NREQ)) ? (sum_s - (IDW+1)'(NREQ)) : sum_s;
      hit_s   = en & ~found_s & req[pos_s[IDW-1:0]];
      grant[pos_s[IDW-1:0]] = grant[pos_s[IDW-1:0]] | hit_s;
      idx     = hit_s ? pos_s[IDW-1:0] : idx;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/proposedadder.sv
// proposedadder: 8-bit approximate pixel adder.
//   a, b : 8-bit unsigned operands
//   s    : 9-bit unsigned approximate sum
// The low nibble is approximated with a bitwise OR; the upper nibble is an
// exact add whose carry-in is a[3] & b[3] (the low nibble's top-bit carry).
module proposedadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] s
);

  logic       carry_s;
  logic [4:0] hi_s;

  assign carry_s = a[3] & b[3];
  assign hi_s    = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, carry_s};
  assign s       = {hi_s, a[3:0] | b[3:0]};

endmodule

// File: rtl/approx_adder_scheduler.sv
// approx_adder_scheduler: shares one proposedadder between NREQ requesters.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   req_valid/req_ready : per-requester handshake; req_ready is the one-hot grant
//   req_a, req_b        : packed 8-bit operands, requester i at [8i+7:8i]
//   req_mode            : packed 2-bit post-process mode per requester
//   out_valid/out_ready : result handshake
//   out_data, out_id    : post-processed result and the requester it belongs to
//   busy                : high whenever an operation is in flight
//   op_count            : wrapping count of completed result handshakes
// Flow: IDLE -(transfer)-> CALC -> OUT -(handshake)-> IDLE, or straight back
// to CALC when a new request is accepted on the handshake cycle.
module approx_adder_scheduler
  import approx_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ*2-1:0] req_mode,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        out_data,
  output logic [IDW-1:0]    out_id,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IDW-1:0]  rr_ptr_r;
  logic [7:0]      a_r;
  logic [7:0]      b_r;
  logic [1:0]      mode_r;
  logic [IDW-1:0]  id_r;
  logic [8:0]      out_data_r;
  logic [IDW-1:0]  out_id_r;
  logic            out_valid_r;
  logic            busy_r;
  logic [CNTW-1:0] op_count_r;

  logic            accept_s;
  logic            transfer_s;
  logic            handshake_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  win_idx_s;
  logic [IDW-1:0]  ptr_nxt_s;
  logic [7:0]      sel_a_s;
  logic [7:0]      sel_b_s;
  logic [1:0]      sel_mode_s;
  logic [8:0]      sum_s;

  // Requests can be taken when idle or when the held result leaves this cycle;
  // never while reset is asserted so req_ready reads 0 during reset.
  always_comb begin
    accept_s = 1'b0;
    if (!rst_n) begin
      accept_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      accept_s = 1'b1;
    end else if ((state_r == ST_OUT) && out_ready) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .en    (accept_s),
    .grant (grant_s),
    .idx   (win_idx_s)
  );

  // The arbiter only grants valid requesters, so any grant is a transfer.
  assign req_ready   = grant_s;
  assign transfer_s  = |grant_s;
  assign handshake_s = out_valid_r & out_ready;
  assign ptr_nxt_s   = (win_idx_s == IDW'(NREQ-1)) ? '0 : (win_idx_s + IDW'(1));

  // One-hot AND-OR mux of the winner's operands and mode.
  always_comb begin
    sel_a_s    = 8'd0;
    sel_b_s    = 8'd0;
    sel_mode_s = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s    = sel_a_s    | (req_a[8*i +: 8]    & {8{grant_s[i]}});
      sel_b_s    = sel_b_s    | (req_b[8*i +: 8]    & {8{grant_s[i]}});
      sel_mode_s = sel_mode_s | (req_mode[2*i +: 2] & {2{grant_s[i]}});
    end
  end

  proposedadder u_add (
    .a (a_r),
    .b (b_r),
    .s (sum_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (transfer_s) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        state_nxt_s = ST_OUT;
      end
      ST_OUT: begin
        if (!out_ready) begin
          state_nxt_s = ST_OUT;
        end else if (transfer_s) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and round-robin pointer advance on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= 8'd0;
      b_r      <= 8'd0;
      mode_r   <= 2'd0;
      id_r     <= '0;
      rr_ptr_r <= '0;
    end else if (transfer_s) begin
      a_r      <= sel_a_s;
      b_r      <= sel_b_s;
      mode_r   <= sel_mode_s;
      id_r     <= win_idx_s;
      rr_ptr_r <= ptr_nxt_s;
    end
  end

  // Result register plus registered out_valid/busy derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= 9'd0;
      out_id_r    <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == ST_OUT);
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (state_r == ST_CALC) begin
        out_data_r <= post_process(sum_s, mode_r);
        out_id_r   <= id_r;
      end
    end
  end

  // Completed-operation counter, wraps naturally at 2^CNTW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= '0;
    end else if (handshake_s) begin
      op_count_r <= op_count_r + CNTW'(1);
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;
  assign busy      = busy_r;
  assign op_count  = op_count_r;

endmodule

// File: tb/tb_approx_adder_scheduler.sv
// Self-checking bench for approx_adder_scheduler (NREQ=4). A second instance
// built with CNTW=4 shares the stimulus to exercise counter wrap.
module tb_approx_adder_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*2-1:0] req_mode;
  logic [NREQ-1:0] req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_data;
  logic [IDW-1:0]  out_id;
  logic            busy;
  logic [15:0]     op_count;

  logic [NREQ-1:0] w_req_ready;
  logic            w_out_valid;
  logic [8:0]      w_out_data;
  logic [IDW-1:0]  w_out_id;
  logic            w_busy;
  logic [3:0]      w_op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ops    = 0;

  approx_adder_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_mode(req_mode), .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .busy(busy), .op_count(op_count)
  );

  approx_adder_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_mode(req_mode), .req_ready(w_req_ready), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_id(w_out_id), .busy(w_busy), .op_count(w_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden approximate sum: OR on the low nibble, exact add of the high
  // nibbles with a carry when both low nibbles are >= 8.
  function automatic int model_sum(input int a, input int b);
    int lo, hi, c;
    lo = (a % 16) | (b % 16);
    c  = ((a % 16) >= 8 && (b % 16) >= 8) ? 1 : 0;
    hi = (a / 16) + (b / 16) + c;
    return hi * 16 + lo;
  endfunction

  function automatic int model_post(input int s, input int m);
    if (m == 1) return (s > 255) ? 255 : s;
    else if (m == 2) return s / 2;
    else return s;
  endfunction

  function automatic int exp_of(input int i);
    return model_post(model_sum(int'(req_a[8*i +: 8]), int'(req_b[8*i +: 8])), int'(req_mode[2*i +: 2]));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Leaves the bench at posedge+1 with reset released and all inputs idle.
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ops = 0;
    @(posedge clk); #1;
  endtask

  // One isolated operation from requester r with full latency/handshake checks.
  task automatic run_single(input int r, input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] m, input int exp_d);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_a[8*r +: 8] = a;
    req_b[8*r +: 8] = b;
    req_mode[2*r +: 2] = m;
    out_ready = 1'b0;
    @(negedge clk);
    chk("single_req_ready", req_ready, 32'(1 << r));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("single_calc_out_valid", out_valid, 0);
    chk("single_calc_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, exp_d);
    chk("single_out_id", out_id, r);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_ops++;
    @(negedge clk);
    chk("single_op_count", op_count, m_ops);
    chk("single_after_valid", out_valid, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    int         exp;
  } vec_t;

  typedef struct {
    int data;
    int id;
  } res_t;

  vec_t tbl[12];
  res_t exp_q[$];

  initial begin
    int m_ptr, win, exp_rdy, exp_d;
    bit have_item, calc_pending, exp_ov, exp_acc;
    res_t item;

    tbl[0]  = '{8'd16,  8'd15,  2'd0, 31};
    tbl[1]  = '{8'hF0,  8'h0F,  2'd0, 255};
    tbl[2]  = '{8'hF0,  8'h0F,  2'd2, 127};
    tbl[3]  = '{8'hF0,  8'h0F,  2'd3, 255};
    tbl[4]  = '{8'hF0,  8'hF0,  2'd1, 255};
    tbl[5]  = '{8'hF0,  8'hF0,  2'd0, 480};
    tbl[6]  = '{8'hF0,  8'hF0,  2'd2, 240};
    tbl[7]  = '{8'hFF,  8'h01,  2'd0, 255};
    tbl[8]  = '{8'h08,  8'h08,  2'd0, 24};
    tbl[9]  = '{8'hFF,  8'hFF,  2'd1, 255};
    tbl[10] = '{8'hFF,  8'hFF,  2'd2, 255};
    tbl[11] = '{8'h00,  8'h00,  2'd1, 0};

    rst_n = 1'b0;
    req_valid = '1; req_a = '0; req_b = '0; req_mode = '0; out_ready = 1'b0;
    #12;
    // Reset values, with requests pending to show req_ready stays low.
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // Table vectors, rotated over the requesters.
    for (int i = 0; i < 12; i++)
      run_single(i % 4, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].exp);
    // Five more random singles against the model, totalling 17 handshakes.
    for (int i = 0; i < 5; i++) begin
      logic [7:0] ra, rb;
      logic [1:0] rm;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      run_single(i % 4, ra, rb, rm, model_post(model_sum(int'(ra), int'(rb)), int'(rm)));
    end
    chk("count_17", op_count, 17);
    chk("count_wrap_cntw4", w_op_count, 1);

    // Fairness: all valid, out_ready high -> grants 0,1,2,3,0 every 2 cycles.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(37 * i + 11);
      req_b[8*i +: 8] = 8'(90 + 23 * i);
      req_mode[2*i +: 2] = 2'(i);
    end
    req_valid = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("fair_req_ready", req_ready, (c % 2 == 0) ? 32'(1 << ((c / 2) % 4)) : 32'd0);
      chk("fair_out_valid", out_valid, (c >= 2 && c % 2 == 0) ? 1 : 0);
      if (c >= 2 && c % 2 == 0) begin
        chk("fair_out_id", out_id, (c / 2 - 1) % 4);
        chk("fair_out_data", out_data, exp_of((c / 2 - 1) % 4));
      end
      @(posedge clk); #1;
    end

    // Back-pressure: hold out_ready low for 5 cycles in OUT.
    do_reset();
    req_valid = '1;
    out_ready = 1'b0;
    exp_d = exp_of(0);
    @(negedge clk);
    chk("bp_first_grant", req_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, exp_d);
      chk("bp_out_id", out_id, 0);
      chk("bp_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 1);
    chk("bp_release_grant", req_ready, 32'b0010);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_count", op_count, 1);
    chk("bp_next_busy", busy, 1);
    chk("bp_next_valid", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_id", out_id, 1);
    chk("bp_next_data", out_data, exp_of(1));
    @(posedge clk); #1;

    // Reset while in CALC discards the operation.
    do_reset();
    run_single(3, 8'h12, 8'h34, 2'd0, model_sum(18, 52));
    req_valid = 4'b0100;
    @(negedge clk);
    chk("midrst_grant", req_ready, 32'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_no_spurious", out_valid, 0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("midrst_ptr_zero", req_ready, 1);
    @(posedge clk); #1;
    req_valid = '0;

    // Randomized run against a transaction-level model.
    do_reset();
    m_ptr = 0; have_item = 0; calc_pending = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        req_a[8*i +: 8] = 8'($urandom_range(0, 255));
        req_b[8*i +: 8] = 8'($urandom_range(0, 255));
        req_mode[2*i +: 2] = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_ov  = have_item && !calc_pending;
      exp_acc = !have_item || (exp_ov && out_ready);
      win = -1;
      if (exp_acc) begin
        for (int k = 0; k < NREQ; k++) begin
          if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        end
      end
      exp_rdy = (win >= 0) ? (1 << win) : 0;
      chk("rand_req_ready", req_ready, exp_rdy);
      chk("rand_out_valid", out_valid, exp_ov);
      chk("rand_op_count", op_count, m_ops);
      if (exp_ov && exp_q.size() > 0) begin
        chk("rand_out_data", out_data, exp_q[0].data);
        chk("rand_out_id", out_id, exp_q[0].id);
      end
      if (exp_ov && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_ops++;
        have_item = 0;
      end
      calc_pending = 0;
      if (win >= 0) begin
        item.data = exp_of(win);
        item.id   = win;
        exp_q.push_back(item);
        have_item = 1;
        calc_pending = 1;
        m_ptr = (win + 1) % NREQ;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(negedge clk);
    chk("rand_final_count", op_count, m_ops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_adder_scheduler.md
Name: approx_adder_scheduler

Overview:
- Shares one instance of the team's 8-bit approximate pixel adder (`proposedadder`: 8-bit a/b in, 9-bit s out) between NREQ pixel-stream requesters.
- Arbitrates round-robin and registers the operands into the adder.
- Captures and post-processes the 9-bit result (raw, saturate or average).
- Returns it with the winning requester's ID over a valid/ready handshake. Sits between the image-line readers and the accumulation/writeback stage.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*8  packed operand A; requester i at bits [8i+7:8i].
- req_b  in  NREQ*8  packed operand B; same packing as req_a.
- req_mode  in  NREQ*2  packed per-requester post-process mode.
- req_ready  out  NREQ  one-hot grant/accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  9  post-processed result.
- out_id  out  IDW  requester index of result.
- busy  out  1  high when state != IDLE.
- op_count  out  CNTW  completed results (wraps).

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE; rr pointer=0.
  - out_valid=0, out_data=0, out_id=0, op_count=0, req_ready=0.
  - Operand/mode registers=0.
  - Reset mid-operation discards the in-flight operation without producing a result; op_count is not incremented.
- Accept condition:
  - Accepted in IDLE, or in OUT on the cycle out_ready=1.
  - req_ready is combinational and one-hot. It is asserted only for the arbiter winner, and only when the accept condition holds; otherwise 0.
  - Transfer on req_valid[i] & req_ready[i]. On transfer, a, b, mode and id are registered.
- Arbitration:
  - Round-robin starting at the rr pointer. The first valid index at or after the pointer (wrapping modulo NREQ) wins.
  - On a transfer, the pointer becomes winner+1 mod NREQ.
  - Requesters without valid are skipped with no penalty.
- FSM:
  - IDLE: if any req_valid, transfer -> CALC; else stay.
  - CALC (1 cycle): adder output s[8:0] from registered operands is post-processed into the result register, out_id is set -> OUT.
  - OUT: out_valid=1; out_data/out_id stable until handshake. On out_valid & out_ready:
    - op_count increments by 1 (wraps at 2^CNTW).
    - If a new transfer occurs the same cycle -> CALC, otherwise -> IDLE.
- Post-process, using the mode registered with the operands:
  - 0 RAW: out_data = s.
  - 1 SAT: out_data = s[8] ? 9'h0FF : {1'b0, s[7:0]}.
  - 2 AVG: out_data = {1'b0, s[8:1]} (floor).
  - 3: reserved, treated as RAW.
- Timing:
  - Latency: out_valid rises 2 cycles after the accepting edge.
  - Peak throughput: one result per 2 cycles with out_ready held high.
- Rules:
  - out_valid never drops without a handshake.
  - req_valid may drop without a transfer; no ordering is guaranteed across requesters.
- Adder arithmetic is the approximate datapath's own; this block adds no correction. The sum is treated as unsigned 9-bit.

Decomposition:
- Package approx_sched_pkg holds:
  - mode constants MODE_RAW=2'd0, MODE_SAT=2'd1, MODE_AVG=2'd2.
  - FSM state encoding ST_IDLE/ST_CALC/ST_OUT.
  - function for the saturate/average post-process.
- Sub-module rr_arbiter (NREQ parameter): inputs request vector, pointer and enable; outputs one-hot grant and encoded index. Unit-testable alone.
- proposedadder is instantiated unchanged as the datapath.

Test Plan:
- Single op: reset, req 0 sends a=16, b=15, mode RAW. Required:
  - req_ready[0] the same cycle.
  - out_valid 2 cycles later with out_data=31, out_id=0.
  - op_count=1 after handshake.
- Fairness: all 4 requesters hold valid with distinct operands, out_ready=1. Required:
  - grant order 0,1,2,3,0.
  - a result every 2 cycles; out_id sequence matches.
- Back-pressure: out_ready=0 for 5 cycles while in OUT. Required:
  - out_data/out_id stable; all req_ready=0.
  - on release, a new transfer happens in the same cycle as the handshake.
- Modes: a=8'hF0, b=8'h0F (carry-free, s=255):
  - RAW -> 255.
  - AVG -> 127.
  - SAT with operands whose modelled s[8]=1 -> 255.
  - Mode 3 -> equals RAW.
  - Every result is compared against the golden approximate-adder model.
- Reset mid-op: rst_n asserted while in CALC, then released. Required:
  - outputs at reset values immediately (async).
  - no spurious out_valid; op_count=0; rr pointer=0.
- Counter wrap (CNTW=4 build): 17 completed handshakes -> op_count=1.
